// File: rtl/nes_video_pkg.sv
// Shared types for the video palette path: palette geometry and the RAM write record.
package nes_video_pkg;

  localparam int PAL_ENTRIES = 64;
  localparam int PAL_BYTES   = 192;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic [5:0] idx;
    rgb_t       rgb;
  } pal_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } pal_state_t;

  // Palette entry addressed by the byte count at the moment its B byte arrives.
  function automatic logic [5:0] entry_of(input logic [7:0] cnt);
    logic [7:0] q;
    q = cnt / 8'd3;
    return q[5:0];
  endfunction

endpackage

// File: rtl/pal_wr_fifo.sv
// Small synchronous FIFO of palette write records with registered full/empty flags.
module pal_wr_fifo
  import nes_video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    push,
  input  logic    pop,
  input  pal_wr_t wdata,
  output pal_wr_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  pal_wr_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (pop && !push)
      count_next = count - (AW+1)'(1);
  end

  // Flags come from the next count so they are exact in the cycle they are seen.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/palette_loader.sv
// Assembles downloaded palette bytes into RGB entries and writes them into the
// video palette RAM, optionally only during vertical blank.
//   state    | meaning
//   ST_IDLE  | no download, no writes
//   ST_LOAD  | download active, bytes assembled and written
//   ST_DRAIN | download ended, flushing buffered entries
module palette_loader
  import nes_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit GATE_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        vblank,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [23:0] load_color_data,
  output logic        pal_valid,
  output logic        pal_error,
  output logic        busy
);

  pal_state_t state, state_next;
  logic       dl_active_q, rise, fall, accept;
  logic [7:0] byte_cnt, cnt_base;
  logic [1:0] phase, phase_base;
  logic [7:0] r_q, g_q;
  logic       push_q;
  pal_wr_t    push_entry, fifo_rdata, wr_entry;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       gate_open, pop_ok, write_go, bypass, drain_done;

  assign rise   = dl_active & ~dl_active_q;
  assign fall   = ~dl_active & dl_active_q;
  assign accept = dl_active & dl_wr & ~dl_wait;

  // A byte on the restart cycle is assembled against a freshly cleared count.
  assign cnt_base   = rise ? '0 : byte_cnt;
  assign phase_base = rise ? '0 : phase;

  assign gate_open  = vblank | ~GATE_BLANK;
  assign pop_ok     = (state != ST_IDLE) & ~rise & gate_open & ~load_color;
  assign write_go   = pop_ok & (~fifo_empty | push_q);
  // An entry arriving at an empty FIFO goes straight to the RAM port.
  assign bypass     = write_go & fifo_empty;
  assign fifo_pop   = write_go & ~fifo_empty;
  assign fifo_push  = push_q & ~rise & ~bypass;
  assign wr_entry   = fifo_empty ? push_entry : fifo_rdata;
  assign drain_done = fifo_empty & ~push_q & ~load_color;

  assign dl_wait = fifo_full;
  assign busy    = (state != ST_IDLE);

  pal_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (rise),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (rise) state_next = ST_LOAD;
      ST_LOAD:  if (fall) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (rise)            state_next = ST_LOAD;
        else if (drain_done) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      dl_active_q      <= 1'b0;
      byte_cnt         <= '0;
      phase            <= '0;
      r_q              <= '0;
      g_q              <= '0;
      push_q           <= 1'b0;
      push_entry       <= '0;
      load_color       <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= '0;
      pal_valid        <= 1'b0;
      pal_error        <= 1'b0;
    end else begin
      state       <= state_next;
      dl_active_q <= dl_active;
      push_q      <= 1'b0;

      // Bytes past the full palette are accepted but dropped.
      if (accept && (cnt_base < 8'(PAL_BYTES))) begin
        byte_cnt <= cnt_base + 8'd1;
        phase    <= (phase_base == 2'd2) ? 2'd0 : phase_base + 2'd1;
        case (phase_base)
          2'd0:    r_q <= dl_data;
          2'd1:    g_q <= dl_data;
          default: begin
            push_q         <= 1'b1;
            push_entry.idx <= entry_of(cnt_base);
            push_entry.rgb <= {r_q, g_q, dl_data};
          end
        endcase
      end else if (rise) begin
        byte_cnt <= '0;
        phase    <= '0;
      end

      load_color <= write_go;
      if (write_go) begin
        load_color_index <= wr_entry.idx;
        load_color_data  <= wr_entry.rgb;
      end

      if (rise) begin
        pal_valid <= 1'b0;
        pal_error <= 1'b0;
      end else if ((state == ST_DRAIN) && drain_done) begin
        pal_valid <= (byte_cnt >= 8'(PAL_BYTES));
        pal_error <= (byte_cnt <  8'(PAL_BYTES));
      end
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: download sequences with hand-computed RAM writes.
module tb_palette_loader;
  import nes_video_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [7:0]  dl_data = 8'h00;
  logic        vblank = 1'b1;
  logic        dl_wait, load_color, pal_valid, pal_error, busy;
  logic [5:0]  load_color_index;
  logic [23:0] load_color_data;

  int checks = 0;
  int failures = 0;
  int rule_viol = 0;
  logic prev_lc = 1'b0;
  logic [5:0]  wr_idx[$];
  logic [23:0] wr_data[$];

  palette_loader #(.FIFO_DEPTH(4), .GATE_BLANK(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .dl_active        (dl_active),
    .dl_wr            (dl_wr),
    .dl_data          (dl_data),
    .dl_wait          (dl_wait),
    .vblank           (vblank),
    .load_color       (load_color),
    .load_color_index (load_color_index),
    .load_color_data  (load_color_data),
    .pal_valid        (pal_valid),
    .pal_error        (pal_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Records every RAM write; flags strobes that are back-to-back or outside LOAD/DRAIN.
  always @(negedge clk) begin
    if (load_color) begin
      wr_idx.push_back(load_color_index);
      wr_data.push_back(load_color_data);
      if (prev_lc || !busy) rule_viol++;
    end
    prev_lc = load_color;
  end

  function automatic logic [23:0] exp_rgb(input int k);
    logic [7:0] a;
    a = 8'(k);
    return {a, a + 8'd1, a + 8'd2};
  endfunction

  function automatic logic [7:0] byte_val(input int j);
    return 8'(j / 3 + j % 3);
  endfunction

  task automatic clear_log();
    wr_idx.delete();
    wr_data.delete();
  endtask

  task automatic start_dl();
    dl_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl();
    dl_wr = 1'b0;
    dl_active = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic w;
    int t;
    dl_wr = 1'b1;
    dl_data = b;
    t = 0;
    do begin
      w = dl_wait;
      @(negedge clk);
      t++;
    end while (w && t < 300);
    if (w) begin
      failures++;
      $display("FAIL send_timeout dl_wait=%0b want 0", w);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dl_wait, load_color, pal_valid, pal_error, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want 00000", {dl_wait, load_color, pal_valid, pal_error, busy});
    end
    checks++;
    if (load_color_index !== 6'd0 || load_color_data !== 24'd0) begin
      failures++;
      $display("FAIL reset_bus idx=%0d data=%h want 0/0", load_color_index, load_color_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_palette();
    clear_log();
    vblank = 1'b1;
    start_dl();
    for (int j = 0; j < 192; j++) send_byte(byte_val(j));
    end_dl();
    wait_idle();
    checks++;
    if (wr_idx.size() !== 64) begin
      failures++;
      $display("FAIL full_count got=%0d want 64", wr_idx.size());
    end
    for (int k = 0; k < 64 && k < wr_idx.size(); k++) begin
      checks++;
      if (wr_idx[k] !== 6'(k) || wr_data[k] !== exp_rgb(k)) begin
        failures++;
        $display("FAIL full_entry%0d got idx=%0d data=%h want idx=%0d data=%h",
                 k, wr_idx[k], wr_data[k], k, exp_rgb(k));
      end
    end
    checks++;
    if (pal_valid !== 1'b1 || pal_error !== 1'b0) begin
      failures++;
      $display("FAIL full_flags valid=%b error=%b want 1/0", pal_valid, pal_error);
    end
  endtask

  task automatic test_blank_gate();
    clear_log();
    vblank = 1'b0;
    start_dl();
    for (int j = 0; j < 12; j++) send_byte(byte_val(j));
    dl_wr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dl_wait !== 1'b1) begin
      failures++;
      $display("FAIL gate_wait got=%b want 1", dl_wait);
    end
    checks++;
    if (wr_idx.size() !== 0) begin
      failures++;
      $display("FAIL gate_closed writes=%0d want 0", wr_idx.size());
    end
    fork
      begin
        repeat (10) @(negedge clk);
        vblank = 1'b1;
      end
      begin
        for (int j = 12; j < 15; j++) send_byte(byte_val(j));
      end
    join
    end_dl();
    wait_idle();
    checks++;
    if (wr_idx.size() !== 5) begin
      failures++;
      $display("FAIL gate_count got=%0d want 5", wr_idx.size());
    end
    for (int k = 0; k < 5 && k < wr_idx.size(); k++) begin
      checks++;
      if (wr_idx[k] !== 6'(k) || wr_data[k] !== exp_rgb(k)) begin
        failures++;
        $display("FAIL gate_entry%0d got idx=%0d data=%h want idx=%0d data=%h",
                 k, wr_idx[k], wr_data[k], k, exp_rgb(k));
      end
    end
    checks++;
    if (pal_error !== 1'b1 || pal_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_flags valid=%b error=%b want 0/1", pal_valid, pal_error);
    end
  endtask

  task automatic test_short_download();
    clear_log();
    vblank = 1'b1;
    start_dl();
    for (int j = 0; j < 100; j++) send_byte(byte_val(j));
    end_dl();
    wait_idle();
    checks++;
    if (wr_idx.size() !== 33) begin
      failures++;
      $display("FAIL short_count got=%0d want 33", wr_idx.size());
    end
    for (int k = 0; k < 33 && k < wr_idx.size(); k++) begin
      checks++;
      if (wr_idx[k] !== 6'(k) || wr_data[k] !== exp_rgb(k)) begin
        failures++;
        $display("FAIL short_entry%0d got idx=%0d data=%h want idx=%0d data=%h",
                 k, wr_idx[k], wr_data[k], k, exp_rgb(k));
      end
    end
    checks++;
    if (pal_error !== 1'b1 || pal_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL short_flags valid=%b error=%b busy=%b want 0/1/0", pal_valid, pal_error, busy);
    end
  endtask

  task automatic test_overlong();
    clear_log();
    vblank = 1'b1;
    start_dl();
    for (int j = 0; j < 200; j++) send_byte((j < 192) ? byte_val(j) : 8'hEE);
    end_dl();
    wait_idle();
    checks++;
    if (wr_idx.size() !== 64) begin
      failures++;
      $display("FAIL long_count got=%0d want 64", wr_idx.size());
    end
    checks++;
    if (wr_idx.size() == 64 && (wr_idx[63] !== 6'd63 || wr_data[63] !== 24'h3F4041)) begin
      failures++;
      $display("FAIL long_last got idx=%0d data=%h want 63/3f4041", wr_idx[63], wr_data[63]);
    end
    checks++;
    if (pal_valid !== 1'b1 || pal_error !== 1'b0) begin
      failures++;
      $display("FAIL long_flags valid=%b error=%b want 1/0", pal_valid, pal_error);
    end
  endtask

  task automatic test_restart_in_drain();
    clear_log();
    vblank = 1'b0;
    start_dl();
    for (int j = 0; j < 9; j++) send_byte(byte_val(j + 30));
    end_dl();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wr_idx.size() !== 0) begin
      failures++;
      $display("FAIL drain_hold busy=%b writes=%0d want 1/0", busy, wr_idx.size());
    end
    dl_active = 1'b1;
    @(negedge clk);
    checks++;
    if (pal_valid !== 1'b0 || pal_error !== 1'b0) begin
      failures++;
      $display("FAIL restart_flags valid=%b error=%b want 0/0", pal_valid, pal_error);
    end
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    end_dl();
    wait_idle();
    checks++;
    if (wr_idx.size() !== 1) begin
      failures++;
      $display("FAIL restart_count got=%0d want 1", wr_idx.size());
    end
    checks++;
    if (wr_idx.size() > 0 && (wr_idx[0] !== 6'd0 || wr_data[0] !== 24'hA0A1A2)) begin
      failures++;
      $display("FAIL restart_entry got idx=%0d data=%h want 0/a0a1a2", wr_idx[0], wr_data[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    vblank = 1'b0;
    start_dl();
    for (int j = 0; j < 12; j++) send_byte(byte_val(j));
    dl_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dl_active = 1'b0;
    @(negedge clk);
    checks++;
    if ({dl_wait, load_color, pal_valid, pal_error, busy} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_flags got=%b want 00000", {dl_wait, load_color, pal_valid, pal_error, busy});
    end
    checks++;
    if (load_color_index !== 6'd0 || load_color_data !== 24'd0) begin
      failures++;
      $display("FAIL midreset_bus idx=%0d data=%h want 0/0", load_color_index, load_color_data);
    end
    reset = 1'b0;
    vblank = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_idx.size() !== 0 || busy !== 1'b0 || dl_wait !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after writes=%0d busy=%b wait=%b want 0/0/0", wr_idx.size(), busy, dl_wait);
    end
  endtask

  initial begin
    test_reset();
    test_full_palette();
    test_blank_gate();
    test_short_download();
    test_overlong();
    test_restart_in_drain();
    test_reset_mid_load();
    checks++;
    if (rule_viol !== 0) begin
      failures++;
      $display("FAIL strobe_rules violations=%0d want 0", rule_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
